// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct encodings, mnemonic kinds and word-packing helpers.
package mips_isa_pkg;
  typedef enum logic [4:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLLV, K_SRLV, K_SRAV,
    K_SLL, K_SRL, K_SRA, K_LW, K_SW, K_BEQ, K_BNE, K_ADDI, K_J
  } kind_e;
  typedef enum logic [1:0] {LOAD, DONE, ERROR} enc_state_e;
  localparam int NUM_KINDS = 17;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [5:0] F_SLLV   = 6'b000100;
  localparam logic [5:0] F_SRLV   = 6'b000110;
  localparam logic [5:0] F_SRAV   = 6'b000111;
  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_SRL    = 6'b000010;
  localparam logic [5:0] F_SRA    = 6'b000011;
  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] shamt, logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction
  function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational map from mnemonic kind and fields to a 32-bit MIPS word.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);
  always_comb begin
    word = '0;
    illegal = 1'b0;
    case (kind)
      K_ADD:   word = r_word(rs, rt, rd, 5'd0, F_ADD);
      K_SUB:   word = r_word(rs, rt, rd, 5'd0, F_SUB);
      K_AND:   word = r_word(rs, rt, rd, 5'd0, F_AND);
      K_OR:    word = r_word(rs, rt, rd, 5'd0, F_OR);
      K_SLT:   word = r_word(rs, rt, rd, 5'd0, F_SLT);
      K_SLLV:  word = r_word(rs, rt, rd, 5'd0, F_SLLV);
      K_SRLV:  word = r_word(rs, rt, rd, 5'd0, F_SRLV);
      K_SRAV:  word = r_word(rs, rt, rd, 5'd0, F_SRAV);
      K_SLL:   word = r_word(5'd0, rt, rd, shamt, F_SLL);
      K_SRL:   word = r_word(5'd0, rt, rd, shamt, F_SRL);
      K_SRA:   word = r_word(5'd0, rt, rd, shamt, F_SRA);
      K_LW:    word = i_word(OP_LW, rs, rt, imm);
      K_SW:    word = i_word(OP_SW, rs, rt, imm);
      K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      K_BNE:   word = i_word(OP_BNE, rs, rt, imm);
      K_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      K_J:     word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic instructions into consecutive imem words via a one-cycle write stage.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);
  enc_state_e state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] word;
  logic illegal, accept, write, clear;
  instr_pack u_pack (
    .kind(in_kind), .rs(in_rs), .rt(in_rt), .rd(in_rd), .shamt(in_shamt),
    .imm(in_imm), .target(in_target), .word(word), .illegal(illegal)
  );
  assign in_ready = state == LOAD;
  assign done = state == DONE;
  assign err = state == ERROR;
  assign accept = in_valid & in_ready;
  assign write = accept & ~illegal;
  assign clear = restart & ~in_ready;
  // a full memory without in_last is an overflow, yet the word in the last slot is still written
  always_comb begin
    next_state = accept ? (illegal ? ERROR : in_last ? DONE : &ptr ? ERROR : LOAD)
               : clear ? LOAD : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      ptr <= '0;
      count <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
    end else begin
      state <= next_state;
      imem_we <= write;
      if (write) begin
        imem_addr <= ptr;
        imem_wdata <= word;
        ptr <= ptr + 1'b1;
        count <= count[ADDR_W] ? count : count + 1'b1;
      end else if (clear) begin
        ptr <= '0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table vectors, corner sequences and randomized stimulus against a behavioural model.
module tb_instr_encoder;
  localparam int CAP = 64;
  localparam int F_TAB [11] = '{32, 34, 36, 37, 42, 4, 6, 7, 0, 2, 3};
  localparam int OP_TAB [5] = '{35, 43, 4, 5, 8};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, restart = 1'b0;
  logic [4:0] in_kind = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic rdy, we, done, err, s_rdy, s_we, s_done, s_err;
  logic [5:0] addr;
  logic [1:0] s_addr;
  logic [31:0] wdata, s_wdata;
  logic [6:0] count;
  logic [2:0] s_count;
  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .restart(restart), .imem_we(we),
    .imem_addr(addr), .imem_wdata(wdata), .count(count), .done(done), .err(err)
  );
  instr_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_rdy), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .restart(restart), .imem_we(s_we),
    .imem_addr(s_addr), .imem_wdata(s_wdata), .count(s_count), .done(s_done), .err(s_err)
  );
  int n_chk = 0, n_fail = 0;
  int m_state = 0, m_ptr = 0, m_count = 0, e_addr = 0;
  bit e_we, e_rst;
  logic [31:0] e_data;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(int k, int rs, int rt, int rd, int sh, int imm, int tgt);
    longint w;
    if (k < 8) w = longint'(rs) * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + F_TAB[k];
    else if (k < 11) w = longint'(rt) * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + F_TAB[k];
    else if (k < 16) w = longint'(OP_TAB[k-11]) * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    else w = longint'(2) * (1 << 26) + tgt;
    return w[31:0];
  endfunction
  task automatic model();
    e_we = 0;
    e_rst = reset;
    if (reset) begin
      m_state = 0; m_ptr = 0; m_count = 0; e_addr = 0; e_data = 0;
    end else if (m_state == 0 && in_valid) begin
      if (in_kind > 16) m_state = 2;
      else begin
        e_we = 1;
        e_addr = m_ptr;
        e_data = ref_word(in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
        m_ptr = (m_ptr + 1) % CAP;
        if (m_count < CAP) m_count++;
        m_state = in_last ? 1 : (e_addr == CAP - 1) ? 2 : 0;
      end
    end else if (m_state != 0 && restart) begin
      m_state = 0; m_ptr = 0; m_count = 0;
    end
  endtask
  task automatic step();
    model();
    @(posedge clk);
    #1;
    check("we", we, e_we);
    if (e_we || e_rst) begin
      check("addr", addr, e_addr);
      check("wdata", wdata, e_data);
    end
    check("count", count, m_count);
    check("in_ready", rdy, m_state == 0);
    check("done", done, m_state == 1);
    check("err", err, m_state == 2);
  endtask
  task automatic drive(bit v, bit rs_p, int k, int rs, int rt, int rd, int sh, int imm, int tgt, bit last);
    in_valid = v; restart = rs_p; in_kind = 5'(k); in_rs = 5'(rs); in_rt = 5'(rt);
    in_rd = 5'(rd); in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
  endtask
  typedef struct {
    bit v; bit rs_p; int k, rs, rt, rd, sh, imm, tgt; bit last;
    bit e_we; int e_addr; logic [31:0] e_data; bit e_done; int e_count;
  } vec_t;
  vec_t tbl [9];
  initial begin
    tbl[0] = '{1, 0, 0, 17, 18, 8, 0, 0, 0, 1, 1, 0, 32'h02324020, 1, 1};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
    tbl[3] = '{1, 0, 11, 29, 8, 0, 0, 4, 0, 0, 1, 0, 32'h8FA80004, 0, 1};
    tbl[4] = '{1, 0, 8, 5, 9, 8, 2, 0, 0, 1, 1, 1, 32'h00094080, 1, 2};
    tbl[5] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
    tbl[6] = '{1, 0, 14, 1, 2, 0, 0, 16'hFFFF, 0, 0, 1, 0, 32'h1422FFFF, 0, 1};
    tbl[7] = '{1, 0, 16, 0, 0, 0, 0, 0, 26'h10, 1, 1, 1, 32'h08000010, 1, 2};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
    reset = 1'b1;
    step();
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].rs_p, tbl[i].k, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh,
            tbl[i].imm, tbl[i].tgt, tbl[i].last);
      step();
      check("tbl_we", we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        check("tbl_addr", addr, tbl[i].e_addr);
        check("tbl_wdata", wdata, tbl[i].e_data);
      end
      check("tbl_done", done, tbl[i].e_done);
      check("tbl_count", count, tbl[i].e_count);
    end
    // overflow on the 4-word instance
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 2, i + 3, 0, 0, 0, 0);
      step();
      check("ovf_we", s_we, 1);
      check("ovf_addr", s_addr, i);
      check("ovf_err", s_err, i == 3);
    end
    check("ovf_ready", s_rdy, 0);
    step();
    check("ovf_5th_we", s_we, 0);
    check("ovf_count", s_count, 4);
    // illegal kind mid-stream, then restart
    drive(1, 0, 31, 1, 2, 3, 0, 0, 0, 0);
    step();
    check("ill_we", we, 0);
    check("ill_err", err, 1);
    check("ill_ready", rdy, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("rs_ready", rdy, 1);
    check("rs_err", err, 0);
    drive(1, 0, 1, 4, 5, 6, 0, 0, 0, 1);
    step();
    check("rs_addr", addr, 0);
    check("rs_wdata", wdata, 32'h00853022);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // reset in the cycle after an accept
    drive(1, 0, 15, 3, 4, 0, 0, 16'h1234, 0, 0);
    step();
    check("pre_rst_we", we, 1);
    reset = 1'b1;
    step();
    check("post_rst_we", we, 0);
    check("post_rst_count", count, 0);
    check("post_rst_addr", addr, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("idle_we", we, 0);
    // randomized stream
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 63) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863),
            $urandom_range(0, 59) == 0);
      reset = $urandom_range(0, 299) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader, the encode-side counterpart of the processor's opcode/funct decode. It accepts one symbolic instruction per cycle (mnemonic kind plus register/immediate fields) over a valid/ready handshake. It packs each instruction into the 32-bit MIPS word the controller decodes, and writes the words to consecutive instruction-memory addresses. It sits between the testbench/boot source and the imem write port.

## Interface
- ADDR_W, 6: imem address width; capacity 2^ADDR_W words
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  encoder can accept (reset 1)
- in_kind  in  5  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLLV, 6 SRLV, 7 SRAV, 8 SLL, 9 SRL, 10 SRA, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 ADDI, 16 J; 17–31 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  I-type immediate / branch word offset
- in_target  in  26  J-type word target
- in_last  in  1  final instruction of program
- restart  in  1  pulse: begin a new load from address 0
- imem_we  out  1  write strobe (reset 0)
- imem_addr  out  ADDR_W  write address (reset 0)
- imem_wdata  out  32  encoded word (reset 0)
- count  out  ADDR_W+1  words written since reset/restart (reset 0)
- done  out  1  program loaded (reset 0)
- err  out  1  sticky: illegal kind or overflow (reset 0)

## Operation
- FSM states: LOAD (reset state), DONE, ERROR.
- in_ready = (state == LOAD) and is a function of state only.
- Accept = in_valid & in_ready.
- Legal accept: register the word and the write pointer. The next cycle has imem_we=1, imem_addr=ptr, imem_wdata=word. ptr and count increment.
- R-type (kinds 0–7): {000000, rs, rt, rd, 00000, funct}. funct values: 100000, 100010, 100100, 100101, 101010, 000100, 000110, 000111.
- Shift-immediate (kinds 8–10): {000000, 00000, rt, rd, shamt, funct}. funct values: 000000, 000010, 000011. in_rs is ignored.
- I-type: {op, rs, rt, imm}. op values: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000. in_rd and in_shamt are ignored.
- J: {000010, target}.
- Fields a kind does not use are forced to zero. in_imm is passed unmodified; no sign handling.
- Accept with in_last=1 moves to DONE.
- Accept into address 2^ADDR_W−1 with in_last=0 moves to ERROR and sets err=1. That final word is still written. Accept with in_last=1 at that address moves to DONE with no error.
- Illegal kind: no write, no ptr change, state goes to ERROR, err=1.
- restart is honoured only in DONE or ERROR. It moves to LOAD and clears ptr, count, done and err. restart is ignored in LOAD.
- Reset at any point returns every output to its reset value and drops a pending write.

## Timing
- Latency: one cycle from accept to imem_we.
- Throughput: one word per cycle while in_valid is held.
- done rises in the same cycle as the final imem_we.
- err rises the cycle after the offending accept.
- in_ready falls the cycle after the terminating accept.
- imem_we is a single-cycle pulse per word. With back-to-back accepts it stays high and the address increments each cycle.
- restart is registered: in_ready=1 the cycle after restart. imem_addr is 0 for the next write.
- count saturates at 2^ADDR_W.

## Structure
- Package mips_isa_pkg holds:
  - opcode and funct localparams, shared with the controller decode;
  - the kind enum (5-bit typedef);
  - NUM_KINDS = 17.
- Sub-module instr_pack is purely combinational. It maps (kind, fields) to (word[31:0], illegal) and can be reused by assembler-style benches.
- instr_encoder holds the FSM, the write pointer and count, and the output register stage.

## Test plan
- ADD rd=8, rs=17, rt=18, last=1 → one write: addr 0, data 0x02324020; done=1 the same cycle; in_ready=0 next cycle.
- LW rt=8, rs=29, imm=4, then SLL rd=8, rt=9, shamt=2, rs=5 (rs must be masked) → data 0x8FA80004 @0, 0x00094080 @1; count=2.
- BNE rs=1, rt=2, imm=0xFFFF, then J target=0x10, last=1, back-to-back → 0x1422FFFF @0, 0x08000010 @1 on consecutive cycles; done=1.
- ADDR_W=2, four ADDs with last=0 → writes at 0..3; err=1 and state ERROR after the 4th; a fifth in_valid is not accepted.
- in_kind=31 mid-stream → no write; err=1; in_ready=0. Then restart → in_ready=1, err=0, next write at addr 0.
- Reset asserted the cycle after an accept → imem_we stays 0 and all outputs return to reset values.
